// File: rtl/udp_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | udp_pkg: shared slot state type, default age limit, saturating add
// | Revision: 1.0
// +------------------------------------------------------------------+
package udp_pkg;

   typedef enum logic [1:0] {
      S_EMPTY    = 2'd0,
      S_FILLING  = 2'd1,
      S_COMPLETE = 2'd2,
      S_DRAINING = 2'd3
   } slot_state_type;

   localparam logic [15:0] c_DEFAULT_AGE_LIMIT = 16'd50000;

   function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
      logic [16:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[16] ? 16'hFFFF : sum[15:0];
   endfunction

endpackage
`default_nettype wire

// File: rtl/udp_fragment_slot_tracker.sv
`default_nettype none
// +------------------------------------------------------------------+
// | udp_fragment_slot_tracker: one reassembly slot FSM with length/age
// | Revision: 1.0
// +------------------------------------------------------------------+
module udp_fragment_slot_tracker
   import udp_pkg::*;
#(
   parameter logic [15:0] AGE_LIMIT = c_DEFAULT_AGE_LIMIT
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        i_push_valid,
   input  logic        i_push_last,
   input  logic [15:0] i_push_packet_id,
   input  logic        i_grant,
   input  logic        i_done,
   output logic        o_empty,
   output logic        o_complete,
   output logic        o_draining,
   output logic [15:0] o_packet_id,
   output logic [15:0] o_length,
   output logic        o_expire,
   output logic        o_protocol_error
);

   slot_state_type r_state;
   slot_state_type w_next_state;
   logic           r_empty;
   logic [15:0]    r_packet_id;
   logic [15:0]    r_length;
   logic [15:0]    r_age;
   logic           w_age_expiring;

   // Expiry lands one cycle later, so flush appears AGE_LIMIT cycles after the last push.
   assign w_age_expiring = (r_age == (AGE_LIMIT - 16'd2));

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_EMPTY;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_EMPTY: begin
            if (i_push_valid && i_push_last) begin
               w_next_state = S_COMPLETE;
            end else if (i_push_valid) begin
               w_next_state = S_FILLING;
            end
         end
         S_FILLING: begin
            if (i_push_last) begin
               w_next_state = S_COMPLETE;
            end else if (!i_push_valid && w_age_expiring) begin
               w_next_state = S_EMPTY;
            end
         end
         S_COMPLETE: begin
            if (i_grant) begin
               w_next_state = S_DRAINING;
            end
         end
         S_DRAINING: begin
            if (i_done) begin
               w_next_state = S_EMPTY;
            end
         end
         default: w_next_state = S_EMPTY;
      endcase
   end

   always_comb begin
      o_complete       = (r_state == S_COMPLETE);
      o_draining       = (r_state == S_DRAINING);
      o_expire         = (r_state == S_FILLING) && !i_push_valid && !i_push_last && w_age_expiring;
      o_protocol_error = ((r_state == S_EMPTY) && i_push_last && !i_push_valid) ||
                         (((r_state == S_COMPLETE) || (r_state == S_DRAINING)) &&
                          (i_push_valid || i_push_last));
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_empty     <= 1'b1;
         r_packet_id <= 16'd0;
         r_length    <= 16'd0;
         r_age       <= 16'd0;
      end else begin
         r_empty <= (w_next_state == S_EMPTY);
         case (r_state)
            S_EMPTY: begin
               if (i_push_valid) begin
                  r_packet_id <= i_push_packet_id;
                  r_length    <= 16'd1;
                  r_age       <= 16'd0;
               end
            end
            S_FILLING: begin
               if (i_push_valid) begin
                  r_length <= sat_add16(r_length, 16'd1);
                  r_age    <= 16'd0;
               end else if (o_expire) begin
                  r_length <= 16'd0;
                  r_age    <= 16'd0;
               end else if (!i_push_last) begin
                  r_age <= r_age + 16'd1;
               end
            end
            S_DRAINING: begin
               if (i_done) begin
                  r_length <= 16'd0;
                  r_age    <= 16'd0;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign o_empty     = r_empty;
   assign o_packet_id = r_packet_id;
   assign o_length    = r_length;

endmodule
`default_nettype wire

// File: rtl/udp_fragment_slot_manager.sv
`default_nettype none
// +------------------------------------------------------------------+
// | udp_fragment_slot_manager: slot trackers, round-robin drain, drops
// | Revision: 1.0
// +------------------------------------------------------------------+
module udp_fragment_slot_manager
   import udp_pkg::*;
#(
   parameter int          FRAGMENT_SLOTS = 4,
   parameter logic [15:0] AGE_LIMIT      = c_DEFAULT_AGE_LIMIT
) (
   input  logic                           clock,
   input  logic                           reset_n,
   input  logic [15:0]                    push_packet_id,
   input  logic [FRAGMENT_SLOTS-1:0]      push_data_valid,
   input  logic [FRAGMENT_SLOTS-1:0]      push_data_last,
   input  logic                           datagram_done,
   output logic [FRAGMENT_SLOTS-1:0]      fragment_slot_empty,
   output logic [FRAGMENT_SLOTS*16-1:0]   fragment_slot_packet_id,
   output logic                           datagram_valid,
   output logic [$clog2(FRAGMENT_SLOTS)-1:0] datagram_slot,
   output logic [15:0]                    datagram_length,
   output logic [15:0]                    datagram_packet_id,
   output logic [FRAGMENT_SLOTS-1:0]      slot_flush,
   output logic [15:0]                    dropped_count,
   output logic                           protocol_error
);

   localparam int c_IDX_W = $clog2(FRAGMENT_SLOTS);

   logic [FRAGMENT_SLOTS-1:0] w_complete;
   logic [FRAGMENT_SLOTS-1:0] w_draining;
   logic [FRAGMENT_SLOTS-1:0] w_expire;
   logic [FRAGMENT_SLOTS-1:0] w_error;
   logic [FRAGMENT_SLOTS-1:0] w_grant;
   logic [15:0]               w_length    [FRAGMENT_SLOTS];
   logic [15:0]               w_packet_id [FRAGMENT_SLOTS];
   logic [15:0]               w_expire_count;
   logic                      w_found;
   logic                      w_grant_en;
   logic [c_IDX_W-1:0]        w_grant_idx;
   logic [c_IDX_W-1:0]        w_probe;

   logic [c_IDX_W-1:0]        r_rr_ptr;
   logic                      r_datagram_valid;
   logic [c_IDX_W-1:0]        r_datagram_slot;
   logic [15:0]               r_datagram_length;
   logic [15:0]               r_datagram_packet_id;
   logic [FRAGMENT_SLOTS-1:0] r_slot_flush;
   logic [15:0]               r_dropped_count;
   logic                      r_protocol_error;

   for (genvar g = 0; g < FRAGMENT_SLOTS; g++) begin : g_slot
      udp_fragment_slot_tracker #(
         .AGE_LIMIT (AGE_LIMIT)
      ) u_tracker (
         .clock            (clock),
         .reset_n          (reset_n),
         .i_push_valid     (push_data_valid[g]),
         .i_push_last      (push_data_last[g]),
         .i_push_packet_id (push_packet_id),
         .i_grant          (w_grant[g]),
         .i_done           (datagram_done),
         .o_empty          (fragment_slot_empty[g]),
         .o_complete       (w_complete[g]),
         .o_draining       (w_draining[g]),
         .o_packet_id      (w_packet_id[g]),
         .o_length         (w_length[g]),
         .o_expire         (w_expire[g]),
         .o_protocol_error (w_error[g])
      );
      assign fragment_slot_packet_id[g*16 +: 16] = w_packet_id[g];
   end

   // Search starts one past the last granted slot so no completed slot starves.
   always_comb begin
      w_found     = 1'b0;
      w_grant_idx = '0;
      w_probe     = '0;
      for (int i = 1; i <= FRAGMENT_SLOTS; i++) begin
         w_probe = r_rr_ptr + c_IDX_W'(i);
         if (!w_found && w_complete[w_probe]) begin
            w_found     = 1'b1;
            w_grant_idx = w_probe;
         end
      end
   end

   assign w_grant_en = w_found && !(|w_draining) && !datagram_done;
   assign w_grant    = w_grant_en ? ({{(FRAGMENT_SLOTS-1){1'b0}}, 1'b1} << w_grant_idx)
                                  : '0;

   always_comb begin
      w_expire_count = 16'd0;
      for (int i = 0; i < FRAGMENT_SLOTS; i++) begin
         w_expire_count = w_expire_count + {15'd0, w_expire[i]};
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_rr_ptr             <= '0;
         r_datagram_valid     <= 1'b0;
         r_datagram_slot      <= '0;
         r_datagram_length    <= 16'd0;
         r_datagram_packet_id <= 16'd0;
         r_slot_flush         <= '0;
         r_dropped_count      <= 16'd0;
         r_protocol_error     <= 1'b0;
      end else begin
         r_slot_flush     <= w_expire;
         r_protocol_error <= |w_error;
         r_dropped_count  <= sat_add16(r_dropped_count, w_expire_count);
         if (w_grant_en) begin
            r_rr_ptr             <= w_grant_idx;
            r_datagram_valid     <= 1'b1;
            r_datagram_slot      <= w_grant_idx;
            r_datagram_length    <= w_length[w_grant_idx];
            r_datagram_packet_id <= w_packet_id[w_grant_idx];
         end else if (datagram_done && r_datagram_valid) begin
            r_datagram_valid <= 1'b0;
         end
      end
   end

   assign datagram_valid     = r_datagram_valid;
   assign datagram_slot      = r_datagram_slot;
   assign datagram_length    = r_datagram_length;
   assign datagram_packet_id = r_datagram_packet_id;
   assign slot_flush         = r_slot_flush;
   assign dropped_count      = r_dropped_count;
   assign protocol_error     = r_protocol_error;

endmodule
`default_nettype wire

// File: tb/tb_udp_fragment_slot_manager.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_udp_fragment_slot_manager: directed self-checking bench
// | Revision: 1.0
// +------------------------------------------------------------------+
module tb_udp_fragment_slot_manager;

   logic        clock;
   logic        reset_n;
   logic [15:0] push_packet_id;
   logic [3:0]  push_data_valid;
   logic [3:0]  push_data_last;
   logic        datagram_done;
   logic [3:0]  fragment_slot_empty;
   logic [63:0] fragment_slot_packet_id;
   logic        datagram_valid;
   logic [1:0]  datagram_slot;
   logic [15:0] datagram_length;
   logic [15:0] datagram_packet_id;
   logic [3:0]  slot_flush;
   logic [15:0] dropped_count;
   logic        protocol_error;

   int n_tests;
   int n_fail;

   udp_fragment_slot_manager #(
      .FRAGMENT_SLOTS (4),
      .AGE_LIMIT      (16'd8)
   ) dut (
      .clock                   (clock),
      .reset_n                 (reset_n),
      .push_packet_id          (push_packet_id),
      .push_data_valid         (push_data_valid),
      .push_data_last          (push_data_last),
      .datagram_done           (datagram_done),
      .fragment_slot_empty     (fragment_slot_empty),
      .fragment_slot_packet_id (fragment_slot_packet_id),
      .datagram_valid          (datagram_valid),
      .datagram_slot           (datagram_slot),
      .datagram_length         (datagram_length),
      .datagram_packet_id      (datagram_packet_id),
      .slot_flush              (slot_flush),
      .dropped_count           (dropped_count),
      .protocol_error          (protocol_error)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic [15:0] id);
      push_data_valid = v;
      push_data_last  = l;
      push_packet_id  = id;
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      reset_n = 1'b0;
      drive(4'b0000, 4'b0000, 16'h0000);
      datagram_done = 1'b0;
      tick();
      tick();
      check("rst_empty", 64'(fragment_slot_empty), 64'hF);
      check("rst_ids", fragment_slot_packet_id, 64'h0);
      check("rst_valid", 64'(datagram_valid), 64'h0);
      check("rst_dropped", 64'(dropped_count), 64'h0);
      check("rst_flush", 64'(slot_flush), 64'h0);
      check("rst_perr", 64'(protocol_error), 64'h0);
      reset_n = 1'b1;
      tick();

      // Slot 1: ten bytes, then last alone
      for (int i = 0; i < 10; i++) begin
         drive(4'b0010, 4'b0000, 16'h1234);
         tick();
         if (i == 0) begin
            check("t1_empty_low", 64'(fragment_slot_empty), 64'hD);
            check("t1_id_latched", 64'(fragment_slot_packet_id[31:16]), 64'h1234);
         end
      end
      drive(4'b0000, 4'b0010, 16'h0000);
      tick();
      drive(4'b0000, 4'b0000, 16'h0000);
      check("t1_valid_n1", 64'(datagram_valid), 64'h0);
      tick();
      check("t1_valid_n2", 64'(datagram_valid), 64'h1);
      check("t1_slot", 64'(datagram_slot), 64'h1);
      check("t1_length", 64'(datagram_length), 64'd10);
      check("t1_id", 64'(datagram_packet_id), 64'h1234);
      datagram_done = 1'b1;
      tick();
      datagram_done = 1'b0;
      check("t1_done_valid", 64'(datagram_valid), 64'h0);
      check("t1_done_empty", 64'(fragment_slot_empty), 64'hF);

      // Slot 3 alone moves the pointer to 3
      drive(4'b1000, 4'b1000, 16'h3333);
      tick();
      drive(4'b0000, 4'b0000, 16'h0000);
      tick();
      check("t2_pre_slot", 64'(datagram_slot), 64'h3);
      datagram_done = 1'b1;
      tick();
      datagram_done = 1'b0;

      // Slots 0, 2, 3 complete together
      drive(4'b1101, 4'b1101, 16'hAAAA);
      tick();
      drive(4'b0000, 4'b0000, 16'h0000);
      tick();
      check("t2_grant_a_valid", 64'(datagram_valid), 64'h1);
      check("t2_grant_a_slot", 64'(datagram_slot), 64'h0);
      check("t2_grant_a_len", 64'(datagram_length), 64'd1);
      datagram_done = 1'b1;
      tick();
      datagram_done = 1'b0;
      tick();
      check("t2_grant_b_slot", 64'(datagram_slot), 64'h2);
      drive(4'b0001, 4'b0001, 16'hBBBB);
      tick();
      drive(4'b0000, 4'b0000, 16'h0000);
      datagram_done = 1'b1;
      tick();
      datagram_done = 1'b0;
      check("t2_gap_valid", 64'(datagram_valid), 64'h0);
      tick();
      check("t2_grant_c_slot", 64'(datagram_slot), 64'h3);
      datagram_done = 1'b1;
      tick();
      datagram_done = 1'b0;
      tick();
      check("t2_grant_d_slot", 64'(datagram_slot), 64'h0);
      check("t2_grant_d_id", 64'(datagram_packet_id), 64'hBBBB);
      datagram_done = 1'b1;
      tick();
      tick();
      datagram_done = 1'b0;
      check("t2_stray_done", 64'(datagram_valid), 64'h0);

      // Slot 2 ages out
      drive(4'b0100, 4'b0000, 16'h0222);
      tick();
      drive(4'b0000, 4'b0000, 16'h0000);
      for (int i = 0; i < 6; i++) tick();
      check("t3_flush_early", 64'(slot_flush), 64'h0);
      tick();
      check("t3_flush", 64'(slot_flush), 64'h4);
      check("t3_dropped", 64'(dropped_count), 64'd1);
      check("t3_empty", 64'(fragment_slot_empty), 64'hF);
      tick();
      check("t3_flush_pulse", 64'(slot_flush), 64'h0);

      // Push on expiry cycle saves the slot
      drive(4'b0100, 4'b0000, 16'h2222);
      tick();
      drive(4'b0000, 4'b0000, 16'h0000);
      for (int i = 0; i < 6; i++) tick();
      drive(4'b0100, 4'b0000, 16'h2222);
      tick();
      check("t4_no_flush", 64'(slot_flush), 64'h0);
      check("t4_still_filling", 64'(fragment_slot_empty), 64'hB);
      check("t4_dropped_same", 64'(dropped_count), 64'd1);

      // Slot 2 completes while 0 and 1 start filling together
      drive(4'b0011, 4'b0100, 16'h2222);
      tick();
      drive(4'b0000, 4'b0000, 16'h0000);
      tick();
      check("t4_slot2", 64'(datagram_slot), 64'h2);
      check("t4_len2", 64'(datagram_length), 64'd2);
      check("t4_id2", 64'(datagram_packet_id), 64'h2222);
      datagram_done = 1'b1;
      tick();
      datagram_done = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      check("t4_dual_early", 64'(slot_flush), 64'h0);
      tick();
      check("t4_dual_flush", 64'(slot_flush), 64'h3);
      check("t4_dual_dropped", 64'(dropped_count), 64'd3);

      // Protocol errors
      drive(4'b0000, 4'b1000, 16'h0000);
      tick();
      drive(4'b0000, 4'b0000, 16'h0000);
      check("t5_last_empty_err", 64'(protocol_error), 64'h1);
      check("t5_last_empty_state", 64'(fragment_slot_empty), 64'hF);
      tick();
      check("t5_err_pulse", 64'(protocol_error), 64'h0);
      drive(4'b0010, 4'b0010, 16'h0101);
      tick();
      drive(4'b0000, 4'b0000, 16'h0000);
      tick();
      check("t5_drain_slot1", 64'(datagram_slot), 64'h1);
      drive(4'b1000, 4'b1000, 16'h0303);
      tick();
      check("t5_no_err", 64'(protocol_error), 64'h0);
      drive(4'b1000, 4'b0000, 16'h0303);
      tick();
      drive(4'b0000, 4'b0000, 16'h0000);
      check("t5_push_complete_err", 64'(protocol_error), 64'h1);
      check("t5_held_slot", 64'(datagram_slot), 64'h1);
      datagram_done = 1'b1;
      tick();
      datagram_done = 1'b0;
      tick();
      check("t5_next_slot3", 64'(datagram_slot), 64'h3);
      check("t5_len_unchanged", 64'(datagram_length), 64'd1);

      // Asynchronous reset while draining
      #2;
      reset_n = 1'b0;
      #1;
      check("t6_valid", 64'(datagram_valid), 64'h0);
      check("t6_empty", 64'(fragment_slot_empty), 64'hF);
      check("t6_dropped", 64'(dropped_count), 64'd0);
      check("t6_flush", 64'(slot_flush), 64'h0);
      tick();
      reset_n = 1'b1;
      tick();
      check("t6_after_release", 64'(datagram_valid), 64'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/udp_fragment_slot_manager.md
# udp_fragment_slot_manager

Owns the UDP reassembly fragment slots: per slot it tracks empty/filling/complete/draining state, latches the IPv4 identification and byte count, and ages out stale partial datagrams. It feeds `fragment_slot_empty` and `fragment_slot_packet_id` back to the UDP receive handler and consumes that handler's push strobes. Completed slots are handed one at a time to the datagram consumer under round-robin scheduling.

## Interface
- `FRAGMENT_SLOTS`, 4: number of slots; power of two, ≥2
- `AGE_LIMIT`, 16'd50000: idle cycles before a filling slot is dropped; ≥2
- `clock` in 1: clock
- `reset_n` in 1: reset, asynchronous, active-low
- `push_packet_id` in 16: IPv4 identification of the current push
- `push_data_valid` in FRAGMENT_SLOTS: one-hot byte-push strobe per slot
- `push_data_last` in FRAGMENT_SLOTS: one-hot datagram-complete strobe; may arrive without valid
- `datagram_done` in 1: consumer finished draining the offered slot
- `fragment_slot_empty` out FRAGMENT_SLOTS: slot free
- `fragment_slot_packet_id` out FRAGMENT_SLOTS×16: latched identification per slot
- `datagram_valid` out 1: a completed slot is offered
- `datagram_slot` out $clog2(FRAGMENT_SLOTS): offered slot index
- `datagram_length` out 16: byte count of offered slot
- `datagram_packet_id` out 16: identification of offered slot
- `slot_flush` out FRAGMENT_SLOTS: one-cycle pulse; clear that slot's FIFO (timeout)
- `dropped_count` out 16: saturating count of timed-out slots
- `protocol_error` out 1: one-cycle pulse on push to a non-accepting slot

## Operation
- Per-slot states: S_EMPTY, S_FILLING, S_COMPLETE, S_DRAINING.
- S_EMPTY: valid → S_FILLING, latch `push_packet_id`, length=1, age=0. Valid+last together → S_COMPLETE, length=1. Last alone → ignored, `protocol_error`.
- S_FILLING: valid → length+1 (saturates at 16'hFFFF), age=0. Last (with or without valid) → S_COMPLETE. Neither → age+1; when age reaches AGE_LIMIT-1 → S_EMPTY, `slot_flush` pulse, `dropped_count`+1. Valid on the expiry cycle wins: no drop.
- S_COMPLETE: waits for grant; no aging.
- S_DRAINING: `datagram_done` → S_EMPTY (length, age cleared; packet_id retained).
- Valid or last to a slot in S_COMPLETE/S_DRAINING: ignored, `protocol_error` pulse.
- Scheduler: at most one slot in S_DRAINING. When none is draining and no `datagram_done` this cycle, grant the first S_COMPLETE slot searching upward from (last granted + 1) mod FRAGMENT_SLOTS; granted slot → S_DRAINING; pointer updated.
- `datagram_valid` = some slot in S_DRAINING; slot/length/id registered at grant, held stable until done.
- `datagram_done` while `datagram_valid` low: ignored.
- Multiple simultaneous timeouts: `dropped_count` += number expiring, saturating at 16'hFFFF.

## Timing
- Reset: all slots S_EMPTY; `fragment_slot_empty` all ones; packet_ids, length, age, `datagram_*`, `slot_flush`, `dropped_count`, `protocol_error`, RR pointer all 0. Reset mid-datagram discards all state; no flush pulse.
- All outputs registered.
- Valid at cycle N → `fragment_slot_empty` low and packet_id updated at N+1.
- Last at N → S_COMPLETE at N+1 → `datagram_valid` at N+2 (if idle).
- Done at M → `datagram_valid` low and slot empty at M+1; next grant valid earliest M+2.
- Timeout: with last activity at N, flush/drop occur at N+AGE_LIMIT; `slot_flush` is a single pulse.

## Structure
- `udp_pkg`: `slot_state_type` enum, default AGE_LIMIT constant.
- Sub-module `udp_fragment_slot_tracker`: one slot's FSM, length and age counters, instantiated per slot via generate; top holds scheduler, drop counter and error merge.

## Test plan
- Push 10 bytes id 0x1234 to slot 1, then last → empty[1]=0, valid 2 cycles after last, slot=1, length=10, id=0x1234; done → empty[1]=1 next cycle.
- Complete slots 0, 2, 3 in the same cycle → grants in order 0, 2, 3; after another slot-0 completion, order continues 0 only after 3.
- AGE_LIMIT=8: one push to slot 2, then idle → `slot_flush`=4'b0100 exactly 8 cycles later, `dropped_count`=1, empty[2]=1.
- Push on the expiry cycle → no flush; slots 0 and 1 expiring together → `dropped_count`+2.
- Push to slot in S_COMPLETE, and last to S_EMPTY → `protocol_error` pulse each, state unchanged.
- Assert reset_n low while draining → `datagram_valid`=0, all empty, `dropped_count`=0 immediately.
